// File: rtl/pdh_cmd_ctrl_if.sv
// PS GPIO word pair: command word from the PS and status word back to it.
interface pdh_cmd_ctrl_if #(
   parameter int AXI_GPIO_IN_WIDTH  = 32,
   parameter int AXI_GPIO_OUT_WIDTH = 32
);
   logic [AXI_GPIO_IN_WIDTH-1:0]  axi_from_ps;
   logic [AXI_GPIO_OUT_WIDTH-1:0] axi_to_ps;

   modport master (output axi_from_ps, input axi_to_ps);
   modport slave  (input axi_from_ps, output axi_to_ps);
endinterface

// File: rtl/pdh_cmd_ctrl.sv
// Toggle-handshaked PS command decoder, config register file for pdh_core,
// and triangle DAC sweep used to search for cavity resonance before lock.
module pdh_cmd_ctrl #(
   parameter int N_REGS             = 8,
   parameter int DATA_WIDTH         = 16,
   parameter int DAC_DATA_WIDTH     = 14,
   parameter int AXI_GPIO_IN_WIDTH  = 32,
   parameter int AXI_GPIO_OUT_WIDTH = 32
) (
   input  logic                                clk,
   input  logic                                rst_n,
   pdh_cmd_ctrl_if.slave                       bus,
   output logic [N_REGS*DATA_WIDTH-1:0]        cfg_o,
   output logic signed [DAC_DATA_WIDTH-1:0]    dac_sweep_o,
   output logic                                sweep_active_o
);

   typedef enum logic [1:0] {CMD_IDLE, CMD_LATCH, CMD_EXEC, CMD_ACK} cmd_state_t;
   typedef enum logic [1:0] {SWEEP_IDLE = 2'b00, SWEEP_UP = 2'b01, SWEEP_DOWN = 2'b10} sweep_state_t;

   localparam logic [3:0] OP_NOP         = 4'd0;
   localparam logic [3:0] OP_WRITE       = 4'd1;
   localparam logic [3:0] OP_READ        = 4'd2;
   localparam logic [3:0] OP_SWEEP_START = 4'd3;
   localparam logic [3:0] OP_SWEEP_STOP  = 4'd4;
   localparam logic [3:0] OP_CLR_ERR     = 4'd5;
   localparam logic [3:0] OP_CFG_RESET   = 4'd6;

   cmd_state_t                cmd_state;
   sweep_state_t              sweep_state;
   logic                      strobe_meta, strobe_sync, strobe_prev;
   logic [3:0]                pl_op, op, last_op;
   logic [2:0]                pl_addr, addr;
   logic [DATA_WIDTH-1:0]     pl_data, data, rdata;
   logic                      ack, err;
   logic [DATA_WIDTH-1:0]     regs [N_REGS];
   logic [DATA_WIDTH-1:0]     dwell_cnt;
   logic                      cmd_err, addr_bad, sweep_start_req, sweep_stop_req;
   logic                      unused_rsvd;
   logic signed [DAC_DATA_WIDTH:0] sw_start, sw_stop, sw_step, sw_cur, sw_next;

   assign unused_rsvd    = ^bus.axi_from_ps[23:16];
   assign sweep_active_o = (sweep_state != SWEEP_IDLE);
   assign bus.axi_to_ps  = AXI_GPIO_OUT_WIDTH'({ack, sweep_state, err, last_op, 8'h00, rdata});

   always_comb begin
      cfg_o = '0;
      for (int k = 0; k < N_REGS; k++) cfg_o[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
   end

   // One extra sign bit keeps start/stop comparisons and step arithmetic from wrapping.
   assign sw_start = $signed({regs[4][DAC_DATA_WIDTH-1], regs[4][DAC_DATA_WIDTH-1:0]});
   assign sw_stop  = $signed({regs[5][DAC_DATA_WIDTH-1], regs[5][DAC_DATA_WIDTH-1:0]});
   assign sw_step  = $signed({1'b0, regs[6][DAC_DATA_WIDTH-1:0]});
   assign sw_cur   = $signed({dac_sweep_o[DAC_DATA_WIDTH-1], dac_sweep_o});
   assign sw_next  = (sweep_state == SWEEP_DOWN) ? sw_cur - sw_step : sw_cur + sw_step;

   always_comb begin
      addr_bad = (32'(addr) >= N_REGS);
      cmd_err  = 1'b0;
      case (op)
         OP_NOP, OP_SWEEP_STOP, OP_CLR_ERR: cmd_err = 1'b0;
         OP_WRITE:       cmd_err = addr_bad || (addr >= 3'd4 && sweep_active_o);
         OP_READ:        cmd_err = addr_bad;
         OP_SWEEP_START: cmd_err = (sw_step == '0) || (sw_start >= sw_stop) || sweep_active_o;
         OP_CFG_RESET:   cmd_err = sweep_active_o;
         default:        cmd_err = 1'b1;
      endcase
      sweep_start_req = (cmd_state == CMD_EXEC) && (op == OP_SWEEP_START) && !cmd_err;
      sweep_stop_req  = (cmd_state == CMD_EXEC) && (op == OP_SWEEP_STOP);
   end

   // strobe_prev only advances when a command is accepted, so toggles seen
   // while busy are picked up once the FSM is back in CMD_IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         strobe_meta <= 1'b0;
         strobe_sync <= 1'b0;
         strobe_prev <= 1'b0;
         cmd_state   <= CMD_IDLE;
         pl_op       <= '0;
         pl_addr     <= '0;
         pl_data     <= '0;
         op          <= '0;
         addr        <= '0;
         data        <= '0;
         ack         <= 1'b0;
         err         <= 1'b0;
         last_op     <= '0;
         rdata       <= '0;
         for (int k = 0; k < N_REGS; k++) regs[k] <= '0;
      end else begin
         strobe_meta <= bus.axi_from_ps[AXI_GPIO_IN_WIDTH-1];
         strobe_sync <= strobe_meta;
         case (cmd_state)
            CMD_IDLE: begin
               if (strobe_sync != strobe_prev) begin
                  strobe_prev <= strobe_sync;
                  pl_op       <= bus.axi_from_ps[30:27];
                  pl_addr     <= bus.axi_from_ps[26:24];
                  pl_data     <= bus.axi_from_ps[DATA_WIDTH-1:0];
                  cmd_state   <= CMD_LATCH;
               end
            end
            CMD_LATCH: begin
               op        <= pl_op;
               addr      <= pl_addr;
               data      <= pl_data;
               cmd_state <= CMD_EXEC;
            end
            CMD_EXEC: begin
               if (cmd_err) begin
                  err <= 1'b1;
               end else begin
                  case (op)
                     OP_WRITE:     regs[addr] <= data;
                     OP_READ:      rdata <= regs[addr];
                     OP_CLR_ERR:   err <= 1'b0;
                     OP_CFG_RESET: for (int k = 0; k < N_REGS; k++) regs[k] <= '0;
                     default:      ;
                  endcase
               end
               cmd_state <= CMD_ACK;
            end
            default: begin
               ack       <= ~ack;
               last_op   <= op;
               cmd_state <= CMD_IDLE;
            end
         endcase
      end
   end

   // Each sample is held for dwell+1 cycles; the ends clamp to start/stop and reverse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sweep_state <= SWEEP_IDLE;
         dac_sweep_o <= '0;
         dwell_cnt   <= '0;
      end else if (sweep_start_req) begin
         sweep_state <= SWEEP_UP;
         dac_sweep_o <= sw_start[DAC_DATA_WIDTH-1:0];
         dwell_cnt   <= '0;
      end else if (sweep_stop_req) begin
         sweep_state <= SWEEP_IDLE;
      end else if (sweep_state != SWEEP_IDLE) begin
         if (dwell_cnt == regs[7]) begin
            dwell_cnt <= '0;
            if (sweep_state == SWEEP_UP) begin
               if (sw_next >= sw_stop) begin
                  dac_sweep_o <= sw_stop[DAC_DATA_WIDTH-1:0];
                  sweep_state <= SWEEP_DOWN;
               end else begin
                  dac_sweep_o <= sw_next[DAC_DATA_WIDTH-1:0];
               end
            end else begin
               if (sw_next <= sw_start) begin
                  dac_sweep_o <= sw_start[DAC_DATA_WIDTH-1:0];
                  sweep_state <= SWEEP_UP;
               end else begin
                  dac_sweep_o <= sw_next[DAC_DATA_WIDTH-1:0];
               end
            end
         end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pdh_cmd_ctrl.sv
// Self-checking bench for pdh_cmd_ctrl: command table, hand-written corner
// sequences and random commands against a behavioural model of the PS view.
module tb_pdh_cmd_ctrl;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic [127:0]        cfg;
   logic signed [13:0]  dac;
   logic                active;
   logic                strobe = 1'b0;

   pdh_cmd_ctrl_if bus ();

   pdh_cmd_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .cfg_o          (cfg),
      .dac_sweep_o    (dac),
      .sweep_active_o (active)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] mRegs [8];
   logic        mErr = 1'b0, mAck = 1'b0, mActive = 1'b0;
   logic [3:0]  mLastOp = '0;
   logic [15:0] mRdata = '0;
   int          mStart, mStop, mStep, mDwell, mEs;
   int          mHeld = 0;
   logic        modelOn = 1'b0, busy = 1'b1;

   typedef struct {
      logic [3:0]  op;
      logic [2:0]  addr;
      logic [15:0] data;
      logic        expErr;
      logic [15:0] expRdata;
      logic        expActive;
   } vec_t;
   vec_t vecs [$];

   int expVal [8] = '{-4, -1, 2, 4, 1, -2, -4, -1};
   int expSt  [8] = '{1, 1, 1, 2, 2, 2, 1, 1};

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int sx14(input logic [15:0] w);
      logic signed [13:0] s;
      s = w[13:0];
      return int'(s);
   endfunction

   // Value of the k-th sample of the triangle and whether it heads upward.
   function automatic void triValue(input int s, input int e, input int st, input int k,
                                    output int v, output logic up);
      v = s;
      up = 1'b1;
      for (int i = 0; i < k; i++) begin
         if (up) begin
            v = v + st;
            if (v >= e) begin v = e; up = 1'b0; end
         end else begin
            v = v - st;
            if (v <= s) begin v = s; up = 1'b1; end
         end
      end
   endfunction

   function automatic void expSweep(output int v, output logic [1:0] st);
      logic up;
      if (mActive) begin
         triValue(mStart, mStop, mStep, (cyc - mEs) / (mDwell + 1), v, up);
         st = up ? 2'b01 : 2'b10;
      end else begin
         v = mHeld;
         st = 2'b00;
      end
   endfunction

   function automatic logic [31:0] expStatus();
      int v;
      logic [1:0] st;
      expSweep(v, st);
      return {mAck, st, mErr, mLastOp, 8'h00, mRdata};
   endfunction

   function automatic logic [127:0] expCfg();
      logic [127:0] r;
      for (int k = 0; k < 8; k++) r[16*k +: 16] = mRegs[k];
      return r;
   endfunction

   task automatic modelReset();
      for (int k = 0; k < 8; k++) mRegs[k] = '0;
      mErr = 1'b0; mAck = 1'b0; mActive = 1'b0;
      mLastOp = '0; mRdata = '0; mHeld = 0;
   endtask

   // Called on the cycle the ack is seen; the command executed one edge earlier.
   task automatic modelCommand(input logic [3:0] op, input logic [2:0] addr, input logic [15:0] data);
      int   e, v;
      logic up;
      e = cyc - 1;
      case (op)
         4'd0: ;
         4'd1: if (addr >= 3'd4 && mActive) mErr = 1'b1; else mRegs[addr] = data;
         4'd2: mRdata = mRegs[addr];
         4'd3: begin
            if (mRegs[6][13:0] == 14'd0 || sx14(mRegs[4]) >= sx14(mRegs[5]) || mActive) begin
               mErr = 1'b1;
            end else begin
               mActive = 1'b1;
               mStart  = sx14(mRegs[4]);
               mStop   = sx14(mRegs[5]);
               mStep   = int'(mRegs[6][13:0]);
               mDwell  = int'(mRegs[7]);
               mEs     = e;
            end
         end
         4'd4: if (mActive) begin
            triValue(mStart, mStop, mStep, (e - 1 - mEs) / (mDwell + 1), v, up);
            mHeld = v;
            mActive = 1'b0;
         end
         4'd5: mErr = 1'b0;
         4'd6: if (mActive) mErr = 1'b1; else for (int k = 0; k < 8; k++) mRegs[k] = '0;
         default: mErr = 1'b1;
      endcase
      mLastOp = op;
      mAck = ~mAck;
   endtask

   // Issue one command from a falling edge and wait (bounded) for its ack.
   task automatic applyStimulus(input logic [3:0] op, input logic [2:0] addr, input logic [15:0] data);
      int   waits;
      logic ackOld;
      busy = 1'b1;
      ackOld = bus.axi_to_ps[31];
      strobe = ~strobe;
      bus.axi_from_ps = {strobe, op, addr, 8'($urandom), data};
      waits = 0;
      do begin
         @(negedge clk);
         waits++;
      end while (bus.axi_to_ps[31] == ackOld && waits < 20);
      checkOutput("ack_latency", 128'(waits), 128'(6));
      modelCommand(op, addr, data);
      checkOutput("status", 128'(bus.axi_to_ps), 128'(expStatus()));
      checkOutput("cfg", cfg, expCfg());
      busy = 1'b0;
   endtask

   always @(negedge clk) begin
      int v;
      logic [1:0] st;
      if (modelOn && !busy && rst_n) begin
         expSweep(v, st);
         checkOutput("sweep_dac", {114'd0, dac}, {114'd0, 14'(v)});
         checkOutput("sweep_state", {126'd0, bus.axi_to_ps[30:29]}, {126'd0, st});
         checkOutput("sweep_active", {127'd0, active}, {127'd0, st != 2'b00});
      end
   end

   task automatic addVec(input logic [3:0] op, input logic [2:0] addr, input logic [15:0] data,
                         input logic expErr, input logic [15:0] expRdata, input logic expActive);
      vecs.push_back('{op, addr, data, expErr, expRdata, expActive});
   endtask

   initial begin
      int          toggles, r;
      logic        ackPrev;
      logic [3:0]  op;
      logic [2:0]  addr;
      logic [15:0] data;

      addVec(4'd1, 3'd2, 16'h1234, 1'b0, 16'h0000, 1'b0);
      addVec(4'd2, 3'd2, 16'h0000, 1'b0, 16'h1234, 1'b0);
      addVec(4'd9, 3'd0, 16'h0000, 1'b1, 16'h1234, 1'b0);
      addVec(4'd5, 3'd0, 16'h0000, 1'b0, 16'h1234, 1'b0);
      addVec(4'd1, 3'd4, 16'h0005, 1'b0, 16'h1234, 1'b0);
      addVec(4'd1, 3'd5, 16'h000A, 1'b0, 16'h1234, 1'b0);
      addVec(4'd1, 3'd6, 16'h0000, 1'b0, 16'h1234, 1'b0);
      addVec(4'd3, 3'd0, 16'h0000, 1'b1, 16'h1234, 1'b0);
      addVec(4'd5, 3'd0, 16'h0000, 1'b0, 16'h1234, 1'b0);
      addVec(4'd1, 3'd6, 16'h0002, 1'b0, 16'h1234, 1'b0);
      addVec(4'd1, 3'd5, 16'h0005, 1'b0, 16'h1234, 1'b0);
      addVec(4'd3, 3'd0, 16'h0000, 1'b1, 16'h1234, 1'b0);
      addVec(4'd5, 3'd0, 16'h0000, 1'b0, 16'h1234, 1'b0);
      addVec(4'd1, 3'd5, 16'h2000, 1'b0, 16'h1234, 1'b0);
      addVec(4'd3, 3'd0, 16'h0000, 1'b1, 16'h1234, 1'b0);
      addVec(4'd5, 3'd0, 16'h0000, 1'b0, 16'h1234, 1'b0);
      addVec(4'd1, 3'd5, 16'h0009, 1'b0, 16'h1234, 1'b0);
      addVec(4'd1, 3'd7, 16'h0003, 1'b0, 16'h1234, 1'b0);
      addVec(4'd3, 3'd0, 16'h0000, 1'b0, 16'h1234, 1'b1);
      addVec(4'd1, 3'd5, 16'h0123, 1'b1, 16'h1234, 1'b1);
      addVec(4'd6, 3'd0, 16'h0000, 1'b1, 16'h1234, 1'b1);
      addVec(4'd3, 3'd0, 16'h0000, 1'b1, 16'h1234, 1'b1);
      addVec(4'd5, 3'd0, 16'h0000, 1'b0, 16'h1234, 1'b1);
      addVec(4'd1, 3'd1, 16'h00AA, 1'b0, 16'h1234, 1'b1);
      addVec(4'd4, 3'd0, 16'h0000, 1'b0, 16'h1234, 1'b0);
      addVec(4'd4, 3'd0, 16'h0000, 1'b0, 16'h1234, 1'b0);
      addVec(4'd2, 3'd5, 16'h0000, 1'b0, 16'h0009, 1'b0);
      addVec(4'd15, 3'd0, 16'h0000, 1'b1, 16'h0009, 1'b0);
      addVec(4'd5, 3'd0, 16'h0000, 1'b0, 16'h0009, 1'b0);
      addVec(4'd6, 3'd0, 16'h0000, 1'b0, 16'h0009, 1'b0);
      addVec(4'd2, 3'd2, 16'h0000, 1'b0, 16'h0000, 1'b0);

      bus.axi_from_ps = '0;
      modelReset();
      repeat (2) @(negedge clk);
      checkOutput("reset_status", 128'(bus.axi_to_ps), 128'(0));
      checkOutput("reset_cfg", cfg, 128'(0));
      checkOutput("reset_dac", {114'd0, dac}, 128'(0));
      checkOutput("reset_active", {127'd0, active}, 128'(0));
      rst_n = 1'b1;
      @(negedge clk);
      modelOn = 1'b1;
      busy = 1'b0;

      $display("[TB] command table");
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].data);
         checkOutput("tbl_err", {127'd0, bus.axi_to_ps[28]}, {127'd0, vecs[i].expErr});
         checkOutput("tbl_rdata", {112'd0, bus.axi_to_ps[15:0]}, {112'd0, vecs[i].expRdata});
         checkOutput("tbl_active", {127'd0, active}, {127'd0, vecs[i].expActive});
         checkOutput("tbl_lastop", {124'd0, bus.axi_to_ps[27:24]}, {124'd0, vecs[i].op});
      end

      $display("[TB] back-to-back strobes");
      busy = 1'b1;
      ackPrev = bus.axi_to_ps[31];
      strobe = ~strobe;
      bus.axi_from_ps = {strobe, 4'd1, 3'd1, 8'h00, 16'h00A5};
      repeat (2) @(negedge clk);
      strobe = ~strobe;
      bus.axi_from_ps = {strobe, 4'd1, 3'd1, 8'h00, 16'h00A5};
      toggles = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.axi_to_ps[31] != ackPrev) toggles++;
         ackPrev = bus.axi_to_ps[31];
      end
      checkOutput("b2b_acks", 128'(toggles), 128'(2));
      modelCommand(4'd1, 3'd1, 16'h00A5);
      modelCommand(4'd1, 3'd1, 16'h00A5);
      checkOutput("b2b_status", 128'(bus.axi_to_ps), 128'(expStatus()));
      checkOutput("b2b_cfg", cfg, expCfg());
      busy = 1'b0;

      $display("[TB] triangle sweep");
      applyStimulus(4'd1, 3'd4, 16'hFFFC);
      applyStimulus(4'd1, 3'd5, 16'h0004);
      applyStimulus(4'd1, 3'd6, 16'h0003);
      applyStimulus(4'd1, 3'd7, 16'h0001);
      applyStimulus(4'd3, 3'd0, 16'h0000);
      for (int j = 1; j < 16; j++) begin
         checkOutput("hand_dac", {114'd0, dac}, {114'd0, 14'(expVal[j/2])});
         checkOutput("hand_state", {126'd0, bus.axi_to_ps[30:29]}, {126'd0, 2'(expSt[j/2])});
         @(negedge clk);
      end

      $display("[TB] reset during sweep");
      @(posedge clk);
      #2;
      busy = 1'b1;
      rst_n = 1'b0;
      strobe = 1'b0;
      bus.axi_from_ps = '0;
      #1;
      checkOutput("midrst_status", 128'(bus.axi_to_ps), 128'(0));
      checkOutput("midrst_cfg", cfg, 128'(0));
      checkOutput("midrst_dac", {114'd0, dac}, 128'(0));
      checkOutput("midrst_active", {127'd0, active}, 128'(0));
      modelReset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      checkOutput("no_spurious_ack", 128'(bus.axi_to_ps), 128'(0));
      busy = 1'b0;

      $display("[TB] random commands");
      for (int i = 0; i < 80; i++) begin
         r = int'($urandom_range(0, 99));
         if (r < 30)      op = 4'd1;
         else if (r < 40) op = 4'd2;
         else if (r < 55) op = 4'd3;
         else if (r < 65) op = 4'd4;
         else if (r < 72) op = 4'd5;
         else if (r < 76) op = 4'd6;
         else if (r < 82) op = 4'd0;
         else             op = 4'($urandom_range(7, 15));
         addr = 3'($urandom);
         if (op == 4'd1 && $urandom_range(0, 1) == 1) addr = 3'($urandom_range(4, 7));
         case (addr)
            3'd4, 3'd5: data = 16'(int'($urandom_range(0, 400)) - 200);
            3'd6:       data = 16'($urandom_range(0, 30));
            3'd7:       data = 16'($urandom_range(0, 3));
            default:    data = 16'($urandom);
         endcase
         applyStimulus(op, addr, data);
         repeat ($urandom_range(0, 12)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pdh_cmd_ctrl.md
Name: pdh_cmd_ctrl

Overview:
Command sequencer between the PS GPIO words (axi_from_ps / axi_to_ps) and the PDH datapath. It decodes toggle-handshaked commands from the PS and holds an 8-entry configuration register file that drives pdh_core's gains and setpoints. It also runs a triangle DAC sweep used for cavity-resonance search before lock. It runs on pdh_clk, beside pdh_core.

Parameters:
N_REGS, 8, number of 16-bit config registers (max 8, addressed by 3 bits)
DATA_WIDTH, 16, config register width
DAC_DATA_WIDTH, 14, sweep output width (signed)
AXI_GPIO_IN_WIDTH, 32, PS->PL command word width
AXI_GPIO_OUT_WIDTH, 32, PL->PS status word width

Ports:
clk  in  1  pdh_clk, single clock domain
rst_n  in  1  asynchronous active-low reset
axi_from_ps_i  in  32  command word: [31] strobe toggle, [30:27] opcode, [26:24] addr, [23:16] reserved, [15:0] data
axi_to_ps_o  out  32  status word: [31] ack toggle, [30:29] sweep state, [28] sticky error, [27:24] last opcode, [23:16] zero, [15:0] rdata
cfg_o  out  N_REGS*16  flat register file; reg k at [16k+15:16k]
dac_sweep_o  out  14  signed sweep value
sweep_active_o  out  1  high while sweep FSM is not IDLE

Behaviour:
- Reset (async, rst_n=0): all regs 0, axi_to_ps_o=0, dac_sweep_o=0, sweep_active_o=0, both FSMs in IDLE, sync flops 0.
- Strobe path: bit 31 passes through a 2-flop synchronizer, then edge detect against the previous synced value. Any change is one command.
- Payload bits [30:0] are sampled once, on the cycle the edge is detected. The PS holds the payload stable from its strobe toggle until it sees ack.
- Command FSM states:
  - CMD_IDLE: go to CMD_LATCH on a detected edge.
  - CMD_LATCH: capture opcode, addr and data.
  - CMD_EXEC: apply the command.
  - CMD_ACK: toggle ack, write last opcode, return to CMD_IDLE.
- Latency: ack toggles on the 5th rising edge after the first edge that samples the new strobe value.
- Strobe edges arriving outside CMD_IDLE are not lost. The synced value is compared when the FSM returns to CMD_IDLE, and an edge there starts a new command.
- Opcodes:
  - 0 NOP.
  - 1 WRITE: reg[addr]<=data.
  - 2 READ: rdata<=reg[addr].
  - 3 SWEEP_START.
  - 4 SWEEP_STOP.
  - 5 CLR_ERR: error<=0.
  - 6 CFG_RESET: all regs<=0.
  - Any other opcode: error<=1, no other effect.
- Every command, including errored ones, completes with an ack toggle.
- Error conditions (error<=1, command has no effect):
  - WRITE to addr 4..7 while sweep_active_o=1.
  - CFG_RESET while sweep_active_o=1.
  - SWEEP_START when step(reg6)==0, when start(reg4)>=stop(reg5) as signed 14-bit [13:0], or when a sweep is already active.
  - addr >= N_REGS on WRITE or READ.
- Error is sticky; only CLR_ERR or reset clears it.
- Sweep registers: reg4 start, reg5 stop, reg6 step (unsigned [13:0]), reg7 dwell (unsigned 16-bit).
- Sweep FSM states and encoding: IDLE=00, UP=01, DOWN=10.
  - SWEEP_START: dac_sweep_o<=start, dwell counter<=0, state UP.
  - Each sample is held for dwell+1 cycles. At dwell expiry, UP adds step and DOWN subtracts step.
  - Arithmetic is 15-bit signed, so intermediates never wrap.
  - UP: if the result is >= stop, output stop and go to DOWN.
  - DOWN: if the result is <= start, output start and go to UP.
- SWEEP_STOP: state IDLE, dac_sweep_o holds its last value. SWEEP_STOP while already IDLE is a NOP with no error.
- Status bits [30:29] and sweep_active_o update on the same edge as the state register.
- rst_n asserted mid-command or mid-sweep: immediate return to reset values. A pending strobe edge is discarded, because the sync flops reset to 0.

Test Plan:
- Reset, then toggle strobe with WRITE addr2 data 0x1234 -> ack toggles exactly 5 cycles after sampling; cfg_o[47:32]=0x1234; error=0.
- READ addr2 -> rdata=0x1234, last opcode=2; then opcode 9 -> error=1, ack toggles; CLR_ERR -> error=0.
- reg4=-4, reg5=4, reg6=3, reg7=1, SWEEP_START -> dac_sweep_o sequence -4,-1,2,4,1,-2,-4,-1, each value held 2 cycles, state bits alternating 01/10.
- SWEEP_START with step=0, then with start=5, stop=5 -> error=1 and sweep stays IDLE. During an active sweep, WRITE reg5 and CFG_RESET each -> error=1 and reg5 unchanged.
- Toggle strobe twice within 2 cycles -> two commands execute back-to-back and ack toggles twice. Separately, assert rst_n mid-sweep -> all outputs 0 asynchronously, with no spurious ack after release.
